game_timer_ctrl: RTL
====================

// Module: game_timer_ctrl
// PURPOSE
//  Next-generation game countdown timer with run/pause/expire control.
//  Adds loadable start time, saturating bonus-time add, low-time warning and BCD digits.
//  Advances one count per external 1 Hz tick pulse.
//  Sits between the tick prescaler, game FSM (start/pause/bonus) and the 7-seg display driver.
// PARAMETERS
//  TIMER_BITS  7   width of time value; must satisfy 2**TIMER_BITS > MAX_TIME
//  MAX_TIME    30  reset/clear time and saturation ceiling; must be <= 99 (two BCD digits)
//  WARN_TIME   5   warning asserted when 0 < time <= WARN_TIME while RUN or PAUSED
//  BONUS_BITS  4   width of bonus_amt
// PORTS
//  clk          in   1           system clock
//  reset        in   1           asynchronous, active-low reset
//  tick         in   1           1-cycle enable pulse, one per second
//  start        in   1           pulse: IDLE->RUN, PAUSED->RUN
//  pause        in   1           pulse: RUN->PAUSED
//  clear        in   1           pulse: any state->IDLE, time=MAX_TIME
//  load         in   1           pulse: time=min(load_val,MAX_TIME); honoured in IDLE/PAUSED only
//  load_val     in   TIMER_BITS  value for load
//  bonus        in   1           pulse: add bonus_amt in RUN/PAUSED
//  bonus_amt    in   BONUS_BITS  seconds to add
//  current_time out  TIMER_BITS  registered time value
//  time_tens    out  4           BCD tens of current_time (combinational)
//  time_ones    out  4           BCD ones of current_time (combinational)
//  running      out  1           1 iff state==RUN
//  warning      out  1           low-time flag (see WARN_TIME)
//  timer_done   out  1           level, 1 iff state==EXPIRED
//  done_pulse   out  1           1-cycle pulse on the cycle after entry to EXPIRED
// BEHAVIOUR
//  - Reset: state=IDLE, current_time=MAX_TIME; running, warning, timer_done and done_pulse all 0.
//  - States: IDLE, RUN, PAUSED, EXPIRED. EXPIRED is left only via clear or reset.
//    timer_done is never high merely because of a reset or load.
//  - Same-cycle priority: clear > start/pause > load > tick/bonus. Lower items are ignored that cycle.
//  - tick: decrements only in RUN; ignored in IDLE, PAUSED and EXPIRED.
//  - Next-time arithmetic: nt = t + (bonus ? bonus_amt : 0) - (tick&&RUN ? 1 : 0).
//    Compute in TIMER_BITS+2 bits, clamp to [0, MAX_TIME].
//    Bonus is honoured in RUN/PAUSED only; it saturates at MAX_TIME and never wraps.
//  - RUN with nt==0: go to EXPIRED; current_time=0 in the same update.
//  - start in IDLE with current_time==0: go directly to EXPIRED.
//  - Simultaneous tick+bonus at t=1, bonus_amt=0: expire. With bonus_amt=3: nt=3, stay in RUN.
//  - load in RUN or EXPIRED: ignored; current_time unchanged.
//  - start while RUN and pause while PAUSED/IDLE: no effect.
//  - Latency: input pulse at edge N -> registered outputs change at edge N+1. done_pulse is high the cycle after entry.
//  - BCD outputs follow current_time combinationally; no extra latency.
//  - Reset asserted mid-run: immediate return to reset values; any pending pulse is dropped.
// STRUCTURE
//  - Package game_timer_pkg: state enum (IDLE/RUN/PAUSED/EXPIRED, 2 bits), function sat_clamp.
//  - Sub-module timer_bcd_split: combinational binary(<=99) -> {tens,ones}, double-dabble.
//  - Top: one state register, one time register, done_pulse register; warning derived from registers.
// TESTING
//  1. Reset, start, 30 ticks -> current_time 30..0; timer_done=1 and done_pulse exactly 1 cycle at t=0; further ticks hold 0.
//  2. Run to 10, pause, 5 ticks -> time stays 10. start, 2 ticks -> 8, running=1.
//  3. Time=2 RUN, tick+bonus(bonus_amt=4) same cycle -> 5. Time=28, bonus 15 -> 30 (saturate).
//  4. load_val=100 in IDLE -> current_time=30. load_val=0 then start -> EXPIRED next cycle, done_pulse=1.
//  5. Time=6 RUN, tick -> warning rises at 5, holds through 1, drops at 0; tens/ones track (e.g. 23 -> 2,3).
//  6. clear+start same cycle in RUN -> IDLE, time=30. reset pulled low mid-RUN -> all outputs return to reset values.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the game countdown timer.
// Pure declarations: no latency, no flow control.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Clamp a signed intermediate time into [0, hi].
  function automatic int sat_clamp(input int v, input int hi);
    if (v < 0)
      return 0;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/timer_bcd_split.sv
// Binary (0..99) to two BCD digits via double-dabble.
// Latency: combinational. Backpressure: none.
module timer_bcd_split #(
  parameter int IN_BITS = 7
) (
  input  logic [IN_BITS-1:0] bin,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);

  logic [IN_BITS+7:0] sr;

  always_comb begin
    sr = '0;
    sr[IN_BITS-1:0] = bin;
    for (int i = 0; i < IN_BITS; i++) begin
      if (sr[IN_BITS+3:IN_BITS] >= 4'd5)
        sr[IN_BITS+3:IN_BITS] = sr[IN_BITS+3:IN_BITS] + 4'd3;
      if (sr[IN_BITS+7:IN_BITS+4] >= 4'd5)
        sr[IN_BITS+7:IN_BITS+4] = sr[IN_BITS+7:IN_BITS+4] + 4'd3;
      sr = sr << 1;
    end
    ones = sr[IN_BITS+3:IN_BITS];
    tens = sr[IN_BITS+7:IN_BITS+4];
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Game countdown timer: run/pause/expire, load, saturating bonus, warning, BCD digits.
// Latency: pulse at edge N -> registered outputs at N+1. Backpressure: none.
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int TIMER_BITS = 7,
  parameter int MAX_TIME   = 30,
  parameter int WARN_TIME  = 5,
  parameter int BONUS_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  clear,
  input  logic                  load,
  input  logic [TIMER_BITS-1:0] load_val,
  input  logic                  bonus,
  input  logic [BONUS_BITS-1:0] bonus_amt,
  output logic [TIMER_BITS-1:0] current_time,
  output logic [3:0]            time_tens,
  output logic [3:0]            time_ones,
  output logic                  running,
  output logic                  warning,
  output logic                  timer_done,
  output logic                  done_pulse
);

  localparam logic [TIMER_BITS-1:0] MAX_T  = TIMER_BITS'(MAX_TIME);
  localparam logic [TIMER_BITS-1:0] WARN_T = TIMER_BITS'(WARN_TIME);

  state_t                state, state_nxt;
  logic [TIMER_BITS-1:0] time_nxt;
  logic [TIMER_BITS+1:0] sum_raw, bonus_ext, dec_ext;
  logic                  active;

  assign active = (state == RUN) || (state == PAUSED);

  always_comb begin
    state_nxt = state;
    time_nxt  = current_time;
    bonus_ext = (TIMER_BITS+2)'(bonus ? bonus_amt : '0);
    dec_ext   = (TIMER_BITS+2)'(tick && (state == RUN));
    sum_raw   = {2'b00, current_time} + bonus_ext - dec_ext;
    // Only an action that actually takes effect blocks the lower-priority ones.
    if (clear) begin
      state_nxt = IDLE;
      time_nxt  = MAX_T;
    end else if (start && (state == IDLE || state == PAUSED)) begin
      state_nxt = (state == IDLE && current_time == '0) ? EXPIRED : RUN;
    end else if (pause && state == RUN) begin
      state_nxt = PAUSED;
    end else if (load && (state == IDLE || state == PAUSED)) begin
      time_nxt = (load_val > MAX_T) ? MAX_T : load_val;
    end else if (active) begin
      time_nxt = TIMER_BITS'(sat_clamp(int'($signed(sum_raw)), MAX_TIME));
      if (state == RUN && time_nxt == '0)
        state_nxt = EXPIRED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      current_time <= MAX_T;
      done_pulse   <= 1'b0;
    end else begin
      state        <= state_nxt;
      current_time <= time_nxt;
      done_pulse   <= (state_nxt == EXPIRED) && (state != EXPIRED);
    end
  end

  assign running    = (state == RUN);
  assign timer_done = (state == EXPIRED);
  assign warning    = active && (current_time != '0) && (current_time <= WARN_T);

  timer_bcd_split #(.IN_BITS(TIMER_BITS)) u_bcd (
    .bin  (current_time),
    .tens (time_tens),
    .ones (time_ones)
  );

endmodule
